ptw_walk_cache: RTL

Parametrised, ASID-tagged cache of non-leaf page-table pointers for the PTW. It is the successor to the single-tag ptw_ptecache_entry_t scheme. Supported features:
- configurable depth, VPN/PPN/ASID widths and level count;
- longest-prefix (deepest-level) hit selection;
- free-slot-first / round-robin replacement;
- global-aware flush by ASID.

On a hit the PTW skips upper walk levels and starts the walk at the returned table PPN.

---
 rtl/ptw_walk_cache_pkg.sv | 29 ++
 rtl/ptw_walk_cache_victim.sv | 41 ++++
 rtl/ptw_walk_cache.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ptw_walk_cache_pkg.sv
// rtl/ptw_walk_cache_pkg.sv - shared constants and entry/response types for the PTW walk cache
package ptw_walk_cache_pkg;

  localparam int WALK_CACHE_ENTRIES = 8;
  localparam int PTW_LEVELS         = 3;
  localparam int PTW_LVL_BITS       = 9;
  localparam int VPN_SIZE           = PTW_LEVELS * PTW_LVL_BITS;
  localparam int PPN_SIZE           = 44;
  localparam int ASID_SIZE          = 7;
  localparam int PTW_LVL_W          = $clog2(PTW_LEVELS);

  // 'global' is a reserved word, hence is_global
  typedef struct packed {
    logic                 valid;
    logic                 is_global;
    logic [ASID_SIZE-1:0] asid;
    logic [PTW_LVL_W-1:0] level;
    logic [VPN_SIZE-1:0]  tag;
    logic [PPN_SIZE-1:0]  ppn;
  } ptw_walk_cache_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 hit;
    logic [PTW_LVL_W-1:0] level;
    logic [PPN_SIZE-1:0]  ppn;
  } ptw_walk_cache_resp_t;

endpackage

// File: rtl/ptw_walk_cache_victim.sv
// rtl/ptw_walk_cache_victim.sv - first-free slot encoder with round-robin fallback pointer
module ptw_walk_cache_victim
  import ptw_walk_cache_pkg::*;
#(
  parameter int ENTRIES = WALK_CACHE_ENTRIES,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ENTRIES-1:0] valid_i,
  input  logic               alloc_i,
  output logic [IDX_W-1:0]   victim_o
);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             w_has_free;
  logic [IDX_W-1:0] w_free_idx;

  // Scan downwards so the lowest free index is the one left standing
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign victim_o = w_has_free ? w_free_idx : r_rr_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (alloc_i && !w_has_free) begin
      r_rr_ptr <= (r_rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr_ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ptw_walk_cache.sv
// rtl/ptw_walk_cache.sv - ASID-tagged cache of non-leaf page-table pointers, deepest-level hit wins
module ptw_walk_cache
  import ptw_walk_cache_pkg::*;
#(
  parameter int ENTRIES   = WALK_CACHE_ENTRIES,
  parameter int LEVELS    = PTW_LEVELS,
  parameter int LVL_BITS  = PTW_LVL_BITS,
  parameter int VPN_BITS  = LEVELS * LVL_BITS,
  parameter int PPN_BITS  = PPN_SIZE,
  parameter int ASID_BITS = ASID_SIZE,
  localparam int LVL_W    = $clog2(LEVELS),
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int OCC_W    = $clog2(ENTRIES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lookup_valid_i,
  input  logic [VPN_BITS-1:0]  lookup_vpn_i,
  input  logic [ASID_BITS-1:0] lookup_asid_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [LVL_W-1:0]     resp_level_o,
  output logic [PPN_BITS-1:0]  resp_ppn_o,
  input  logic                 fill_valid_i,
  input  logic [VPN_BITS-1:0]  fill_vpn_i,
  input  logic [ASID_BITS-1:0] fill_asid_i,
  input  logic [LVL_W-1:0]     fill_level_i,
  input  logic [PPN_BITS-1:0]  fill_ppn_i,
  input  logic                 fill_global_i,
  input  logic                 flush_i,
  input  logic                 flush_asid_en_i,
  input  logic [ASID_BITS-1:0] flush_asid_i,
  output logic [OCC_W-1:0]     occupancy_o
);

  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_global;
  logic [ASID_BITS-1:0] r_asid  [ENTRIES];
  logic [LVL_W-1:0]     r_level [ENTRIES];
  logic [VPN_BITS-1:0]  r_tag   [ENTRIES];
  logic [PPN_BITS-1:0]  r_ppn   [ENTRIES];

  logic                 r_resp_valid;
  logic                 r_resp_hit;
  logic [LVL_W-1:0]     r_resp_level;
  logic [PPN_BITS-1:0]  r_resp_ppn;
  logic [OCC_W-1:0]     r_occ;

  logic [ENTRIES-1:0]   w_lk_match;
  logic                 w_lk_hit;
  logic [LVL_W-1:0]     w_lk_level;
  logic [PPN_BITS-1:0]  w_lk_ppn;

  logic [VPN_BITS-1:0]  w_fill_tag;
  logic [ENTRIES-1:0]   w_fill_match;
  logic                 w_fill_ok;
  logic                 w_fill_hit;
  logic [IDX_W-1:0]     w_fill_hit_idx;
  logic                 w_alloc;
  logic [IDX_W-1:0]     w_victim;
  logic [IDX_W-1:0]     w_wr_idx;

  logic [ENTRIES-1:0]   w_valid_nxt;
  logic [ENTRIES-1:0]   w_global_nxt;
  logic [OCC_W-1:0]     w_occ_nxt;
  logic                 w_resp_hit;

  // Level 0 keeps the top LVL_BITS of the VPN; each deeper level keeps one more group
  function automatic logic [VPN_BITS-1:0] prefix_mask(input logic [LVL_W-1:0] lvl);
    logic [VPN_BITS-1:0] m;
    m = '0;
    for (int g = 0; g < LEVELS; g++) begin
      if (g <= int'(lvl)) m[VPN_BITS-1-g*LVL_BITS -: LVL_BITS] = '1;
    end
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_lk_match[i] = r_valid[i] && (r_global[i] || (r_asid[i] == lookup_asid_i)) &&
                      ((lookup_vpn_i & prefix_mask(r_level[i])) == r_tag[i]);
    end
  end

  // Strictly-greater compare keeps the lowest index among equal-depth matches
  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_level = '0;
    w_lk_ppn   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_lk_match[i] && (!w_lk_hit || (r_level[i] > w_lk_level))) begin
        w_lk_hit   = 1'b1;
        w_lk_level = r_level[i];
        w_lk_ppn   = r_ppn[i];
      end
    end
  end

  assign w_fill_tag = fill_vpn_i & prefix_mask(fill_level_i);
  assign w_fill_ok  = fill_valid_i && !flush_i && (int'(fill_level_i) < LEVELS - 1);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_fill_match[i] = r_valid[i] && (r_level[i] == fill_level_i) && (r_tag[i] == w_fill_tag) &&
                        (r_global[i] || (r_asid[i] == fill_asid_i));
    end
  end

  always_comb begin
    w_fill_hit     = 1'b0;
    w_fill_hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_fill_match[i]) begin
        w_fill_hit     = 1'b1;
        w_fill_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_alloc  = w_fill_ok && !w_fill_hit;
  assign w_wr_idx = w_fill_hit ? w_fill_hit_idx : w_victim;

  ptw_walk_cache_victim #(
    .ENTRIES(ENTRIES)
  ) u_victim (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (r_valid),
    .alloc_i (w_alloc),
    .victim_o(w_victim)
  );

  always_comb begin
    w_valid_nxt  = r_valid;
    w_global_nxt = r_global;
    if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!flush_asid_en_i || (!r_global[i] && (r_asid[i] == flush_asid_i))) w_valid_nxt[i] = 1'b0;
      end
    end else if (w_fill_ok) begin
      w_valid_nxt[w_wr_idx]  = 1'b1;
      w_global_nxt[w_wr_idx] = fill_global_i;
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < ENTRIES; i++) w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
  end

  assign w_resp_hit = w_lk_hit && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= '0;
      r_global     <= '0;
      r_occ        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_level <= '0;
      r_resp_ppn   <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_global     <= w_global_nxt;
      r_occ        <= w_occ_nxt;
      r_resp_valid <= lookup_valid_i;
      if (lookup_valid_i) begin
        r_resp_hit   <= w_resp_hit;
        r_resp_level <= w_resp_hit ? w_lk_level + LVL_W'(1) : '0;
        r_resp_ppn   <= w_resp_hit ? w_lk_ppn : '0;
      end
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit
  always_ff @(posedge clk_i) begin
    if (w_fill_ok) begin
      r_ppn[w_wr_idx] <= fill_ppn_i;
      if (!w_fill_hit) begin
        r_asid[w_wr_idx]  <= fill_asid_i;
        r_level[w_wr_idx] <= fill_level_i;
        r_tag[w_wr_idx]   <= w_fill_tag;
      end
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_hit_o   = r_resp_hit;
  assign resp_level_o = r_resp_level;
  assign resp_ppn_o   = r_resp_ppn;
  assign occupancy_o  = r_occ;

endmodule
